// File: rtl/softex_tcdm_responder.sv
`default_nettype none
// ============================================================================
// Module  : softex_tcdm_responder
// Brief   : Single-port HCI-core TCDM target. Byte-enabled word array with a
//           fixed-latency, strictly in-order, credit-bounded response path.
// Rev     : 1.0
// ============================================================================
module softex_tcdm_responder #(
   parameter int DW         = 32,
   parameter int AW         = 32,
   parameter int IW         = 8,
   parameter int DEPTH      = 1024,
   parameter int LATENCY    = 1,
   parameter int RESP_DEPTH = 4
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            clear_i,
   input  logic            stall_i,
   input  logic            tcdm_req_i,
   output logic            tcdm_gnt_o,
   input  logic [AW-1:0]   tcdm_add_i,
   input  logic            tcdm_wen_i,
   input  logic [DW/8-1:0] tcdm_be_i,
   input  logic [DW-1:0]   tcdm_data_i,
   input  logic [IW-1:0]   tcdm_id_i,
   output logic [DW-1:0]   tcdm_r_data_o,
   output logic            tcdm_r_valid_o,
   output logic [IW-1:0]   tcdm_r_id_o,
   input  logic            tcdm_r_ready_i
);

   localparam int c_nbytes = DW / 8;
   localparam int c_off    = $clog2(c_nbytes);
   localparam int c_idx    = $clog2(DEPTH);
   localparam int c_cw     = $clog2(RESP_DEPTH + 1);
   localparam int c_pw     = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

   localparam logic [c_cw-1:0] c_resp_max = c_cw'(RESP_DEPTH);
   localparam logic [c_pw-1:0] c_ptr_last = c_pw'(RESP_DEPTH - 1);

   logic [DW-1:0]      r_mem [DEPTH];

   logic [LATENCY-1:0] r_pipe_valid;
   logic [DW-1:0]      r_pipe_data [LATENCY];
   logic [IW-1:0]      r_pipe_id   [LATENCY];

   logic [DW-1:0]      r_fifo_data [RESP_DEPTH];
   logic [IW-1:0]      r_fifo_id   [RESP_DEPTH];
   logic [c_pw-1:0]    r_wr_ptr;
   logic [c_pw-1:0]    r_rd_ptr;
   logic [c_cw-1:0]    r_fifo_cnt;
   logic [c_cw-1:0]    r_outstanding;

   logic [c_idx-1:0]   w_idx;
   logic               w_accept;
   logic               w_fifo_empty;
   logic               w_pipe_out_valid;
   logic               w_resp_hs;
   logic               w_push;
   logic               w_pop;
   logic               w_unused_addr;

   assign w_idx         = tcdm_add_i[c_off +: c_idx];
   assign w_unused_addr = ^tcdm_add_i;

   // Credit check uses only the registered count, so grant never looks at r_ready.
   assign tcdm_gnt_o = tcdm_req_i & rst_ni & ~clear_i & ~stall_i
                       & (r_outstanding < c_resp_max);
   assign w_accept   = tcdm_gnt_o;

   assign w_fifo_empty     = (r_fifo_cnt == '0);
   assign w_pipe_out_valid = r_pipe_valid[LATENCY-1];

   assign tcdm_r_valid_o = ~w_fifo_empty | w_pipe_out_valid;
   assign tcdm_r_data_o  = w_fifo_empty ? r_pipe_data[LATENCY-1] : r_fifo_data[r_rd_ptr];
   assign tcdm_r_id_o    = w_fifo_empty ? r_pipe_id[LATENCY-1]   : r_fifo_id[r_rd_ptr];

   assign w_resp_hs = tcdm_r_valid_o & tcdm_r_ready_i;
   assign w_pop     = ~w_fifo_empty & tcdm_r_ready_i;
   // Pipeline output is parked in the FIFO unless it leaves via the bypass this cycle.
   assign w_push    = w_pipe_out_valid & ~(w_fifo_empty & tcdm_r_ready_i);

   always_ff @(posedge clk_i) begin
      if (w_accept && !tcdm_wen_i) begin
         for (int b = 0; b < c_nbytes; b++) begin
            if (tcdm_be_i[b]) begin
               r_mem[w_idx][8*b +: 8] <= tcdm_data_i[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         r_pipe_valid <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            r_pipe_data[i] <= '0;
            r_pipe_id[i]   <= '0;
         end
      end else begin
         r_pipe_valid[0] <= w_accept;
         r_pipe_data[0]  <= (w_accept && tcdm_wen_i) ? r_mem[w_idx] : '0;
         r_pipe_id[0]    <= w_accept ? tcdm_id_i : '0;
         for (int i = 1; i < LATENCY; i++) begin
            r_pipe_valid[i] <= r_pipe_valid[i-1];
            r_pipe_data[i]  <= r_pipe_data[i-1];
            r_pipe_id[i]    <= r_pipe_id[i-1];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_fifo_data[r_wr_ptr] <= r_pipe_data[LATENCY-1];
         r_fifo_id[r_wr_ptr]   <= r_pipe_id[LATENCY-1];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clear_i) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_fifo_cnt    <= '0;
         r_outstanding <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + 1'b1;
         end
         r_fifo_cnt    <= r_fifo_cnt + c_cw'(w_push) - c_cw'(w_pop);
         r_outstanding <= r_outstanding + c_cw'(w_accept) - c_cw'(w_resp_hs);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_softex_tcdm_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_softex_tcdm_responder
// Brief   : Directed vector table plus hand-written multi-cycle sequences.
// Rev     : 1.0
// ============================================================================
module tb_softex_tcdm_responder;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int IW = 8;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic            clear_i;
   logic            stall_i;
   logic            tcdm_req_i;
   logic            tcdm_gnt_o;
   logic [AW-1:0]   tcdm_add_i;
   logic            tcdm_wen_i;
   logic [DW/8-1:0] tcdm_be_i;
   logic [DW-1:0]   tcdm_data_i;
   logic [IW-1:0]   tcdm_id_i;
   logic [DW-1:0]   tcdm_r_data_o;
   logic            tcdm_r_valid_o;
   logic [IW-1:0]   tcdm_r_id_o;
   logic            tcdm_r_ready_i;

   int checks   = 0;
   int failures = 0;
   int resp_count;
   int issued;
   bit gnt_seen;
   bit done;

   typedef struct packed {
      logic [31:0] data;
      logic [7:0]  id;
   } resp_t;

   typedef struct {
      bit          req;
      bit          wen;
      bit          stall;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic [7:0]  id;
      bit          e_gnt;
      bit          e_rvalid;
      logic [31:0] e_rdata;
      logic [7:0]  e_rid;
   } vec_t;

   resp_t       sb [$];
   logic [31:0] mem_model [int];
   vec_t        vt [14];

   always #5 clk_i = ~clk_i;

   softex_tcdm_responder #(
      .DW(DW), .AW(AW), .IW(IW), .DEPTH(1024), .LATENCY(1), .RESP_DEPTH(4)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .clear_i        (clear_i),
      .stall_i        (stall_i),
      .tcdm_req_i     (tcdm_req_i),
      .tcdm_gnt_o     (tcdm_gnt_o),
      .tcdm_add_i     (tcdm_add_i),
      .tcdm_wen_i     (tcdm_wen_i),
      .tcdm_be_i      (tcdm_be_i),
      .tcdm_data_i    (tcdm_data_i),
      .tcdm_id_i      (tcdm_id_i),
      .tcdm_r_data_o  (tcdm_r_data_o),
      .tcdm_r_valid_o (tcdm_r_valid_o),
      .tcdm_r_id_o    (tcdm_r_id_o),
      .tcdm_r_ready_i (tcdm_r_ready_i)
   );

   function automatic vec_t mk(bit req, bit wen, bit stall, logic [31:0] addr,
                               logic [31:0] data, logic [3:0] be, logic [7:0] id,
                               bit e_gnt, bit e_rvalid, logic [31:0] e_rdata,
                               logic [7:0] e_rid);
      vec_t v;
      v.req = req; v.wen = wen; v.stall = stall; v.addr = addr; v.data = data;
      v.be = be; v.id = id; v.e_gnt = e_gnt; v.e_rvalid = e_rvalid;
      v.e_rdata = e_rdata; v.e_rid = e_rid;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_idle();
      tcdm_req_i  = 1'b0;
      tcdm_wen_i  = 1'b1;
      tcdm_add_i  = '0;
      tcdm_be_i   = '0;
      tcdm_data_i = '0;
      tcdm_id_i   = '0;
   endtask

   task automatic set_rd(input logic [31:0] addr, input logic [7:0] id);
      tcdm_req_i  = 1'b1;
      tcdm_wen_i  = 1'b1;
      tcdm_add_i  = addr;
      tcdm_be_i   = 4'hF;
      tcdm_data_i = '0;
      tcdm_id_i   = id;
   endtask

   // Expected response of the request currently granted, with model memory update.
   task automatic push_expected();
      resp_t       e;
      int          idx;
      logic [31:0] w;
      idx  = int'((tcdm_add_i >> 2) & 32'h3FF);
      e.id = tcdm_id_i;
      w    = mem_model.exists(idx) ? mem_model[idx] : 32'h0;
      if (tcdm_wen_i) begin
         e.data = w;
      end else begin
         e.data = 32'h0;
         for (int b = 0; b < 4; b++) begin
            if (tcdm_be_i[b]) w[8*b +: 8] = tcdm_data_i[8*b +: 8];
         end
         mem_model[idx] = w;
      end
      sb.push_back(e);
   endtask

   task automatic observe(output bit g);
      resp_t e;
      if (tcdm_r_valid_o && tcdm_r_ready_i) begin
         resp_count++;
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL resp_unexpected: got id 0x%02h expected no response", tcdm_r_id_o);
         end else begin
            e = sb.pop_front();
            check("resp_id", 32'(tcdm_r_id_o), 32'(e.id));
            check("resp_data", tcdm_r_data_o, e.data);
         end
      end
      g = tcdm_gnt_o;
      if (g) push_expected();
   endtask

   initial begin
      rst_ni = 1'b0; clear_i = 1'b0; stall_i = 1'b0; tcdm_r_ready_i = 1'b1;
      set_idle();
      resp_count = 0;

      vt[0]  = mk(0, 1, 0, 32'h0,    32'h0,        4'h0, 8'h00, 0, 0, 32'h0,        8'h00);
      vt[1]  = mk(1, 0, 0, 32'h40,   32'hDEADBEEF, 4'hF, 8'h03, 1, 0, 32'h0,        8'h00);
      vt[2]  = mk(1, 1, 0, 32'h40,   32'h0,        4'h0, 8'h05, 1, 1, 32'h0,        8'h03);
      vt[3]  = mk(1, 0, 0, 32'h80,   32'h11223344, 4'hF, 8'h07, 1, 1, 32'hDEADBEEF, 8'h05);
      vt[4]  = mk(1, 0, 0, 32'h80,   32'hAABBCCDD, 4'h5, 8'h08, 1, 1, 32'h0,        8'h07);
      vt[5]  = mk(1, 1, 0, 32'h80,   32'h0,        4'h0, 8'h09, 1, 1, 32'h0,        8'h08);
      vt[6]  = mk(1, 1, 0, 32'h1080, 32'h0,        4'h0, 8'h0A, 1, 1, 32'h11BB33DD, 8'h09);
      vt[7]  = mk(1, 1, 0, 32'h43,   32'h0,        4'h0, 8'h0B, 1, 1, 32'h11BB33DD, 8'h0A);
      vt[8]  = mk(0, 1, 0, 32'h0,    32'h0,        4'h0, 8'h00, 0, 1, 32'hDEADBEEF, 8'h0B);
      vt[9]  = mk(0, 1, 0, 32'h0,    32'h0,        4'h0, 8'h00, 0, 0, 32'h0,        8'h00);
      vt[10] = mk(1, 1, 1, 32'h40,   32'h0,        4'h0, 8'h0C, 0, 0, 32'h0,        8'h00);
      vt[11] = mk(1, 1, 0, 32'h40,   32'h0,        4'h0, 8'h0C, 1, 0, 32'h0,        8'h00);
      vt[12] = mk(0, 1, 0, 32'h0,    32'h0,        4'h0, 8'h00, 0, 1, 32'hDEADBEEF, 8'h0C);
      vt[13] = mk(0, 1, 0, 32'h0,    32'h0,        4'h0, 8'h00, 0, 0, 32'h0,        8'h00);

      repeat (3) @(posedge clk_i);
      #3;
      check("rst_gnt",    32'(tcdm_gnt_o),     32'h0);
      check("rst_rvalid", 32'(tcdm_r_valid_o), 32'h0);
      check("rst_rdata",  tcdm_r_data_o,       32'h0);
      check("rst_rid",    32'(tcdm_r_id_o),    32'h0);
      rst_ni = 1'b1;
      tick();

      for (int i = 0; i < 14; i++) begin
         tcdm_req_i = vt[i].req;   tcdm_wen_i  = vt[i].wen;  stall_i   = vt[i].stall;
         tcdm_add_i = vt[i].addr;  tcdm_data_i = vt[i].data; tcdm_be_i = vt[i].be;
         tcdm_id_i  = vt[i].id;
         #2;
         check($sformatf("vec%0d_gnt", i),    32'(tcdm_gnt_o),     32'(vt[i].e_gnt));
         check($sformatf("vec%0d_rvalid", i), 32'(tcdm_r_valid_o), 32'(vt[i].e_rvalid));
         check($sformatf("vec%0d_rdata", i),  tcdm_r_data_o,       vt[i].e_rdata);
         check($sformatf("vec%0d_rid", i),    32'(tcdm_r_id_o),    32'(vt[i].e_rid));
         tick();
      end
      stall_i = 1'b0;
      set_idle();

      // 16 back-to-back writes then 16 reads at full rate
      for (int k = 0; k < 32; k++) begin
         tcdm_req_i  = 1'b1;
         tcdm_wen_i  = (k >= 16);
         tcdm_add_i  = 32'h100 + 32'(4 * (k % 16));
         tcdm_be_i   = 4'hF;
         tcdm_data_i = 32'hC0DE0000 | 32'(k);
         tcdm_id_i   = 8'(k);
         #2;
         check($sformatf("b2b_gnt[%0d]", k),    32'(tcdm_gnt_o),     32'h1);
         check($sformatf("b2b_rvalid[%0d]", k), 32'(tcdm_r_valid_o), (k > 0) ? 32'h1 : 32'h0);
         observe(gnt_seen);
         tick();
      end
      set_idle();
      #2;
      check("b2b_tail_rvalid", 32'(tcdm_r_valid_o), 32'h1);
      observe(gnt_seen);
      tick();
      #2;
      check("b2b_idle_rvalid", 32'(tcdm_r_valid_o), 32'h0);
      check("b2b_sb_empty", 32'(sb.size()), 32'h0);
      tick();

      // Backpressure: six reads against a stuck initiator
      tcdm_r_ready_i = 1'b0;
      issued = 0;
      for (int k = 0; k < 6; k++) begin
         set_rd(32'h100 + 32'(4 * issued), 8'(8'h20 + issued));
         #2;
         check($sformatf("bp_gnt[%0d]", k), 32'(tcdm_gnt_o), (k < 4) ? 32'h1 : 32'h0);
         if (k > 0) begin
            check("bp_head_valid", 32'(tcdm_r_valid_o), 32'h1);
            check("bp_head_id",    32'(tcdm_r_id_o),    32'h20);
            check("bp_head_data",  tcdm_r_data_o,       32'hC0DE0000);
         end
         observe(gnt_seen);
         if (gnt_seen) issued++;
         tick();
      end
      tcdm_r_ready_i = 1'b1;
      done = 1'b0;
      for (int c = 0; c < 30 && !done; c++) begin
         if (issued < 6) set_rd(32'h100 + 32'(4 * issued), 8'(8'h20 + issued));
         else set_idle();
         #2;
         if (c == 0) check("bp_gnt_release", 32'(tcdm_gnt_o), 32'h0);
         if (c == 1) check("bp_gnt_resume",  32'(tcdm_gnt_o), 32'h1);
         observe(gnt_seen);
         if (gnt_seen) issued++;
         tick();
         done = (issued == 6) && (sb.size() == 0);
      end
      if (!done) begin
         checks++; failures++;
         $display("FAIL bp_drain_timeout: got issued=%0d pending=%0d required 6 and 0", issued, sb.size());
      end
      set_idle();

      // Stall window inside a read stream
      issued = 0;
      resp_count = 0;
      done = 1'b0;
      for (int c = 0; c < 30 && !done; c++) begin
         stall_i = (c >= 2 && c < 5);
         if (issued < 8) set_rd(32'h100 + 32'(4 * (issued % 16)), 8'(8'h30 + issued));
         else set_idle();
         #2;
         if (stall_i && tcdm_req_i) check($sformatf("stall_gnt[%0d]", c), 32'(tcdm_gnt_o), 32'h0);
         observe(gnt_seen);
         if (gnt_seen) issued++;
         tick();
         done = (issued == 8) && (sb.size() == 0);
      end
      stall_i = 1'b0;
      set_idle();
      check("stall_resp_count", 32'(resp_count), 32'd8);

      // Credit count back at zero: exactly four grants with r_ready low
      tcdm_r_ready_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         set_rd(32'h100 + 32'(4 * k), 8'(8'h40 + k));
         #2;
         check($sformatf("cnt_gnt[%0d]", k), 32'(tcdm_gnt_o), (k < 4) ? 32'h1 : 32'h0);
         observe(gnt_seen);
         tick();
      end
      tcdm_r_ready_i = 1'b1;
      set_idle();
      #2;
      observe(gnt_seen);
      tick();

      // Clear with three outstanding; a same-cycle request must not be granted
      tcdm_r_ready_i = 1'b0;
      clear_i = 1'b1;
      set_rd(32'h80, 8'h50);
      #2;
      check("clear_gnt", 32'(tcdm_gnt_o), 32'h0);
      tick();
      clear_i = 1'b0;
      set_idle();
      sb.delete();
      #2;
      check("clear_rvalid", 32'(tcdm_r_valid_o), 32'h0);
      check("clear_rdata",  tcdm_r_data_o,       32'h0);
      check("clear_rid",    32'(tcdm_r_id_o),    32'h0);
      tick();

      tcdm_r_ready_i = 1'b1;
      set_rd(32'h80, 8'h51);
      #2;
      check("post_clear_gnt", 32'(tcdm_gnt_o), 32'h1);
      tick();
      set_idle();
      #2;
      check("post_clear_rvalid", 32'(tcdm_r_valid_o), 32'h1);
      check("post_clear_rdata",  tcdm_r_data_o,       32'h11BB33DD);
      check("post_clear_rid",    32'(tcdm_r_id_o),    32'h51);
      tick();

      tcdm_r_ready_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         set_rd(32'h100, 8'(8'h60 + k));
         #2;
         check($sformatf("post_clear_cnt_gnt[%0d]", k), 32'(tcdm_gnt_o), (k < 4) ? 32'h1 : 32'h0);
         tick();
      end
      set_idle();
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
